// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that time-shares one ALU among NUM_REQ requesters and
// returns each result, tagged with the requester ID, over a response channel.
module alu_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6,
    parameter int ALU_LAT = 1,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0]     req_op_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
    output logic [OP_W-1:0]             alu_op_o,
    output logic [DATA_W-1:0]           alu_a_o,
    output logic [DATA_W-1:0]           alu_b_o,
    input  logic [DATA_W-1:0]           alu_result_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [ID_W-1:0]             rsp_id_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_err_o,
    output logic                        busy_o,
    output logic [1:0]                  dbg_state_o
);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high. A request may withdraw valid before acceptance but must hold its
    // payload while valid; the response holds id/data/err until it is taken.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int                CNT_W     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0]  EXEC_LAST = CNT_W'(ALU_LAT - 1);
    localparam logic [OP_W-1:0]   OP_MAX    = OP_W'(12);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    scan_id;
    logic               grant_found;
    logic               accept;
    logic               op_legal;
    logic [OP_W-1:0]    grant_op;
    logic [CNT_W-1:0]   exec_cnt_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  data_q;
    logic [ID_W-1:0]    id_q;
    logic               err_q;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid_i[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    assign grant_op = req_op_i[int'(grant_id)*OP_W +: OP_W];
    assign accept   = (state_q == IDLE) && grant_found;
    assign op_legal = (grant_op <= OP_MAX);

    always_comb begin
        req_ready_o = '0;
        if (accept && rst_ni) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = op_legal ? EXEC : RESP;
            EXEC: if (exec_cnt_q == EXEC_LAST) state_d = RESP;
            RESP: if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            exec_cnt_q <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= grant_op;
                a_q        <= req_a_i[int'(grant_id)*DATA_W +: DATA_W];
                b_q        <= req_b_i[int'(grant_id)*DATA_W +: DATA_W];
                id_q       <= grant_id;
                exec_cnt_q <= '0;
                err_q      <= !op_legal;
                if (!op_legal) data_q <= '0;
            end
            if (state_q == EXEC) begin
                exec_cnt_q <= exec_cnt_q + 1'b1;
                if (exec_cnt_q == EXEC_LAST) data_q <= alu_result_i;
            end
            // Pointer moves only after a response is taken, so a lone requester keeps winning.
            if (state_q == RESP && rsp_ready_i) begin
                rr_ptr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration order, latency and results.
module tb_alu_req_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int OW  = 6;
    localparam int LAT = 3;

    logic              clk;
    logic              rst_ni;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N*OW-1:0]   req_op_i;
    logic [N*DW-1:0]   req_a_i;
    logic [N*DW-1:0]   req_b_i;
    logic [OW-1:0]     alu_op_o;
    logic [DW-1:0]     alu_a_o;
    logic [DW-1:0]     alu_b_o;
    logic [DW-1:0]     alu_result_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [1:0]        rsp_id_o;
    logic [DW-1:0]     rsp_data_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic [1:0]        dbg_state_o;

    alu_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(LAT)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial rst_ni = 1'b0;

    // ---------------- ALU stand-in ----------------
    function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a & b;
            6'd3:    return a | b;
            6'd4:    return a ^ b;
            6'd5:    return ~(a | b);
            6'd6:    return a << b[4:0];
            6'd7:    return a >> b[4:0];
            6'd8:    return $unsigned($signed(a) >>> b[4:0]);
            6'd9:    return {31'b0, a == b};
            6'd10:   return {31'b0, a != b};
            6'd11:   return {31'b0, $signed(a) < $signed(b)};
            6'd12:   return {31'b0, $signed(a) > $signed(b)};
            default: return '0;
        endcase
    endfunction

    always_comb alu_result_i = alu_ref(alu_op_o, alu_a_o, alu_b_o);

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [34:0] exp_q[$];          // {id[1:0], err, data[31:0]}
    int          rr_ptr = 0;
    logic        m_busy = 1'b0;
    logic        m_legal = 1'b0;
    logic [OW-1:0] m_op;
    logic [DW-1:0] m_a, m_b;
    int          m_rsp_cyc = 0;
    int          cyc = 0;

    logic          cur_valid [N];
    logic [OW-1:0] cur_op [N];
    logic [DW-1:0] cur_a [N];
    logic [DW-1:0] cur_b [N];
    logic          cur_rsp_ready = 1'b0;
    logic          auto_rearm = 1'b0;
    logic          legal_only = 1'b0;
    logic          log_grants = 1'b0;
    int            grant_log[$];
    int            grant_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        for (int k = 0; k < N; k++) begin
            req_valid_i[k]            = cur_valid[k];
            req_op_i[k*OW +: OW]      = cur_op[k];
            req_a_i[k*DW +: DW]       = cur_a[k];
            req_b_i[k*DW +: DW]       = cur_b[k];
        end
        rsp_ready_i = cur_rsp_ready;
    endtask

    task automatic new_req(input int k);
        cur_valid[k] = 1'b1;
        if (legal_only || $urandom_range(0, 7) != 0) cur_op[k] = 6'($urandom_range(0, 12));
        else cur_op[k] = 6'($urandom_range(13, 63));
        cur_a[k] = $urandom();
        cur_b[k] = ($urandom_range(0, 3) == 0) ? cur_a[k] : $urandom();
    endtask

    task automatic set_req(input int k, input logic [OW-1:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        cur_valid[k] = 1'b1;
        cur_op[k]    = op;
        cur_a[k]     = a;
        cur_b[k]     = b;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N; k++) cur_valid[k] = 1'b0;
    endtask

    // One cycle: drive at negedge, compare against the model, then apply the
    // transfer (if any) that the next rising edge performs.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        logic         legal;
        logic [34:0]  front;
        int           w;
        @(negedge clk);
        apply_inputs();
        #1;
        exp_ready = '0;
        w = -1;
        if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                if (w < 0 && cur_valid[(rr_ptr + i) % N]) w = (rr_ptr + i) % N;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        exp_rv = m_busy && (cyc >= m_rsp_cyc);
        check("ready", 64'(req_ready_o), 64'(exp_ready));
        check("busy", 64'(busy_o), 64'(m_busy));
        check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
        if (exp_rv) begin
            front = exp_q[0];
            check("rsp_id", 64'(rsp_id_o), 64'(front[34:33]));
            check("rsp_err", 64'(rsp_err_o), 64'(front[32]));
            check("rsp_data", 64'(rsp_data_o), 64'(front[31:0]));
        end
        if (m_busy && m_legal && !exp_rv) begin
            check("alu_op", 64'(alu_op_o), 64'(m_op));
            check("alu_a", 64'(alu_a_o), 64'(m_a));
            check("alu_b", 64'(alu_b_o), 64'(m_b));
        end
        if (log_grants && req_ready_o != '0) begin
            for (int k = 0; k < N; k++) if (req_ready_o[k]) grant_log.push_back(k);
            grant_cyc.push_back(cyc);
        end
        if (w >= 0) begin
            legal = (cur_op[w] <= 6'd12);
            exp_q.push_back({2'(w), !legal, legal ? alu_ref(cur_op[w], cur_a[w], cur_b[w]) : 32'h0});
            m_busy    = 1'b1;
            m_legal   = legal;
            m_op      = cur_op[w];
            m_a       = cur_a[w];
            m_b       = cur_b[w];
            m_rsp_cyc = cyc + (legal ? LAT + 1 : 1);
            if (auto_rearm) new_req(w);
            else cur_valid[w] = 1'b0;
        end else if (exp_rv && cur_rsp_ready) begin
            rr_ptr = (int'(exp_q[0][34:33]) + 1) % N;
            void'(exp_q.pop_front());
            m_busy = 1'b0;
        end
        cyc++;
    endtask

    task automatic drain(input int max);
        clear_reqs();
        cur_rsp_ready = 1'b1;
        for (int i = 0; i < max && m_busy; i++) step();
        step();
    endtask

    // Accept one request from requester k alone; returns edges from accept to rsp_valid.
    task automatic run_single(input int k, input logic [OW-1:0] op, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, output int lat);
        clear_reqs();
        cur_rsp_ready = 1'b0;
        set_req(k, op, a, b);
        step();
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid_o) break;
            lat++;
        end
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int lat;
        for (int k = 0; k < N; k++) new_req(k);
        apply_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 64'(req_ready_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_state", 64'(dbg_state_o), 64'(0));
        check("rst_alu", {26'b0, alu_op_o, alu_a_o}, 64'(0));
        check("rst_rsp", {29'b0, rsp_id_o, rsp_err_o, rsp_data_o}, 64'(0));
        clear_reqs();
        apply_inputs();
        @(negedge clk);
        rst_ni = 1'b1;

        // All requesters busy: strict rotation from pointer 0
        legal_only = 1'b1;
        auto_rearm = 1'b1;
        log_grants = 1'b1;
        cur_rsp_ready = 1'b1;
        for (int k = 0; k < N; k++) new_req(k);
        repeat (5 * (LAT + 2) + 2) step();
        auto_rearm = 1'b0;
        log_grants = 1'b0;
        check("t2_grants", 64'(grant_log.size() >= 5), 64'(1));
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check("t2_order", 64'(grant_log[i]), 64'(exp_order[i]));
            if (i > 0 && i < grant_cyc.size())
                check("t2_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(LAT + 2));
        end
        drain(50);

        // Lone ADD
        run_single(2, 6'd0, 32'd5, 32'd7, lat);
        check("t1_lat", 64'(lat), 64'(LAT + 1));
        check("t1_id", 64'(rsp_id_o), 64'(2));
        check("t1_data", 64'(rsp_data_o), 64'(12));
        check("t1_err", 64'(rsp_err_o), 64'(0));
        drain(20);

        // Illegal opcode skips execution
        run_single(1, 6'd20, 32'h1234, 32'h5678, lat);
        check("t3_lat", 64'(lat), 64'(1));
        check("t3_id", 64'(rsp_id_o), 64'(1));
        check("t3_err", 64'(rsp_err_o), 64'(1));
        check("t3_data", 64'(rsp_data_o), 64'(0));
        drain(20);

        // Response backpressure with other requesters waiting
        run_single(0, 6'd1, 32'd3, 32'd5, lat);
        new_req(1);
        new_req(3);
        repeat (10) begin
            step();
            check("t4_valid", 64'(rsp_valid_o), 64'(1));
            check("t4_data", 64'(rsp_data_o), 64'(32'hFFFF_FFFE));
            check("t4_ready", 64'(req_ready_o), 64'(0));
        end
        drain(50);

        // Shift held across the full multi-cycle execution
        run_single(3, 6'd6, 32'd1, 32'd4, lat);
        check("t5_lat", 64'(lat), 64'(LAT + 1));
        check("t5_data", 64'(rsp_data_o), 64'(16));
        drain(20);

        // Reset in the middle of execution
        run_single(2, 6'd0, 32'd1, 32'd1, lat);
        drain(20);
        clear_reqs();
        set_req(1, 6'd2, 32'hFF, 32'h0F);
        step();
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_busy", 64'(busy_o), 64'(0));
        check("t6_state", 64'(dbg_state_o), 64'(0));
        check("t6_alu", {26'b0, alu_op_o, alu_a_o}, 64'(0));
        check("t6_rsp", {31'b0, rsp_valid_o, rsp_data_o}, 64'(0));
        exp_q.delete();
        m_busy = 1'b0;
        rr_ptr = 0;
        clear_reqs();
        apply_inputs();
        @(negedge clk);
        rst_ni = 1'b1;
        new_req(3);
        new_req(0);
        step();
        check("t6_grant", 64'(req_ready_o), 64'(4'b0001));
        drain(20);

        // Random traffic
        legal_only = 1'b0;
        repeat (1500) begin
            for (int k = 0; k < N; k++) begin
                if (cur_valid[k]) begin
                    if ($urandom_range(0, 19) == 0) cur_valid[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    new_req(k);
                end
            end
            cur_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
